// File: rtl/led_pat_pkg.sv
// led_pat_pkg: shared definitions for the LED pattern player.
//   - stateT     : sequencer state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   - PAT_LEN_DEF: default number of steps per pattern
//   - PAT0..PAT3 : pattern table, bit i drives the LED during step i
//   - patBit()   : table lookup by pattern select and step index
package led_pat_pkg;

    localparam int unsigned PAT_LEN_DEF = 12;
    localparam int unsigned NUM_PAT     = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned STEP_W      = 4;
    localparam int unsigned REP_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } stateT;

    // Words are 16 bits wide so any PAT_LEN up to 16 indexes safely; unused bits are 0.
    localparam logic [15:0] PAT0 = 16'h0CE8; // 0,0,0,1,0,1,1,1,0,0,1,1
    localparam logic [15:0] PAT1 = 16'h0AAA; // 0,1,0,1,0,1,0,1,0,1,0,1
    localparam logic [15:0] PAT2 = 16'h0041; // 1,0,0,0,0,0,1,0,0,0,0,0
    localparam logic [15:0] PAT3 = 16'h003F; // 1,1,1,1,1,1,0,0,0,0,0,0

    function automatic logic patBit(input logic [SEL_W-1:0] sel, input logic [STEP_W-1:0] step);
        logic [15:0] word;
        case (sel)
            2'd0:    word = PAT0;
            2'd1:    word = PAT1;
            2'd2:    word = PAT2;
            default: word = PAT3;
        endcase
        return word[step];
    endfunction

endpackage

// File: rtl/led_step_tick.sv
// led_step_tick: step-rate enable generator for the LED pattern player.
//   iCLK  : system clock
//   iRST  : synchronous active-high reset
//   iCLR  : clears the counter (has priority over iEN)
//   iEN   : counter advances only while high
//   oTICK : one-cycle enable, high while the counter sits at TICK_DIV-1
module led_step_tick #(
    parameter int unsigned TICK_DIV = 2000000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iCLR,
    input  logic iEN,
    output logic oTICK
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] cntD;
    logic             atMax;

    // Exact match only, so the counter can never run past the terminal value.
    assign atMax = (cntQ == CNT_MAX);

    always_comb begin
        cntD = cntQ;
        if (iCLR) begin
            cntD = '0;
        end else if (iEN) begin
            cntD = atMax ? '0 : cntQ + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign oTICK = iEN && atMax;

endmodule

// File: rtl/led_pattern_sched.sv
// led_pattern_sched: start/stop-controlled, repeatable LED pattern player.
//   iCLK   : system clock, all logic on posedge
//   iRST   : synchronous active-high reset
//   iSTART : play request, accepted only while oREADY=1
//   iSEL   : pattern index, latched on accept
//   iREP   : extra repeats, latched on accept (0 = play once)
//   iSTOP  : abort playback (LOAD/RUN only)
//   oREADY : high in IDLE
//   oBUSY  : high in LOAD and RUN
//   oLED   : registered LED drive
//   oSTEP  : registered current step index
//   oDONE  : one-cycle pulse on normal completion
module led_pattern_sched
    import led_pat_pkg::*;
#(
    parameter int unsigned TICK_DIV = 2000000,
    parameter int unsigned PAT_LEN  = PAT_LEN_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic [SEL_W-1:0]  iSEL,
    input  logic [REP_W-1:0]  iREP,
    input  logic              iSTOP,
    output logic              oREADY,
    output logic              oBUSY,
    output logic              oLED,
    output logic [STEP_W-1:0] oSTEP,
    output logic              oDONE
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PAT_LEN - 1);

    stateT             stateQ, stateD;
    logic [STEP_W-1:0] stepQ, stepD;
    logic [REP_W-1:0]  repCntQ, repCntD;
    logic [SEL_W-1:0]  selQ, selD;
    logic [REP_W-1:0]  repQ, repD;
    logic              ledQ, ledD;
    logic              tick;
    logic              tickClr;
    logic              tickEn;

    // Counter only runs in RUN; clearing on iSTOP keeps it at 0 from the first IDLE cycle.
    assign tickEn  = (stateQ == RUN);
    assign tickClr = (stateQ != RUN) || iSTOP;

    led_step_tick #(
        .TICK_DIV (TICK_DIV)
    ) uStepTick (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iCLR  (tickClr),
        .iEN   (tickEn),
        .oTICK (tick)
    );

    always_comb begin
        stateD  = stateQ;
        stepD   = stepQ;
        repCntD = repCntQ;
        selD    = selQ;
        repD    = repQ;
        ledD    = ledQ;

        unique case (stateQ)
            IDLE: begin
                ledD  = 1'b0;
                stepD = '0;
                if (iSTART) begin
                    selD   = iSEL;
                    repD   = iREP;
                    stateD = LOAD;
                end
            end
            LOAD: begin
                if (iSTOP) begin
                    stateD = IDLE;
                    ledD   = 1'b0;
                    stepD  = '0;
                end else begin
                    stepD   = '0;
                    repCntD = repQ;
                    ledD    = patBit(selQ, '0);
                    stateD  = RUN;
                end
            end
            RUN: begin
                // Stop has priority over a coincident step tick.
                if (iSTOP) begin
                    stateD = IDLE;
                    ledD   = 1'b0;
                    stepD  = '0;
                end else if (tick) begin
                    if (stepQ != LAST_STEP) begin
                        stepD = stepQ + 1'b1;
                        ledD  = patBit(selQ, stepQ + 1'b1);
                    end else if (repCntQ != '0) begin
                        repCntD = repCntQ - 1'b1;
                        stepD   = '0;
                        ledD    = patBit(selQ, '0);
                    end else begin
                        stateD = DONE;
                        stepD  = '0;
                        ledD   = 1'b0;
                    end
                end
            end
            DONE: begin
                stateD = IDLE;
                stepD  = '0;
                ledD   = 1'b0;
            end
            default: begin
                stateD = IDLE;
                stepD  = '0;
                ledD   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ  <= IDLE;
            stepQ   <= '0;
            repCntQ <= '0;
            selQ    <= '0;
            repQ    <= '0;
            ledQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            stepQ   <= stepD;
            repCntQ <= repCntD;
            selQ    <= selD;
            repQ    <= repD;
            ledQ    <= ledD;
        end
    end

    // Status outputs decode the registered state directly.
    assign oREADY = (stateQ == IDLE);
    assign oBUSY  = (stateQ == LOAD) || (stateQ == RUN);
    assign oDONE  = (stateQ == DONE);
    assign oLED   = ledQ;
    assign oSTEP  = stepQ;

endmodule

// File: doc/led_pattern_sched.md
Name: led_pattern_sched

Overview:
- Sequencer for the board LED pattern player: accepts play requests (pattern select, repeat count) through a ready/start handshake.
- Generates its own step tick, walks a 12-step pattern table and drives oLED.
- Reports busy and done to the top-level control logic.
- Replaces the free-running, self-timed LED pattern loop with a start/stop-controlled, repeatable player.

Parameters:
- TICK_DIV, 2000000, iCLK cycles per pattern step (100 ms at 20 MHz); minimum 2.
- PAT_LEN, 12, steps per pattern; range 2..16.
- NUM_PAT, 4, patterns in the table; sets the iSEL width of 2.

Ports:
- iCLK  input  1  system clock, all logic on posedge.
- iRST  input  1  synchronous reset, active-high.
- iSTART  input  1  play request; accepted only when oREADY=1.
- iSEL  input  2  pattern index, sampled on accept.
- iREP  input  4  extra repeats, sampled on accept; 0 = play once, 15 = play 16 times.
- iSTOP  input  1  abort playback.
- oREADY  output  1  high in IDLE only.
- oBUSY  output  1  high in LOAD and RUN.
- oLED  output  1  registered LED drive.
- oSTEP  output  4  current step index, registered.
- oDONE  output  1  one-cycle pulse on normal completion.

Behaviour:
Reset and handshake:
- Reset at a posedge forces state=IDLE, tick counter=0, step=0, repeat counter=0, oLED=0, oSTEP=0, oDONE=0, oBUSY=0. oREADY=1 from the first cycle after reset.
- Reset mid-RUN aborts immediately; no oDONE.
- Handshake: a request is accepted at the posedge where state=IDLE and iSTART=1. iSEL and iREP are latched at that edge.
- iSTART in any other state is ignored. There is no queueing.

State machine, IDLE -> LOAD -> RUN -> DONE -> IDLE:
- IDLE: oLED=0, oSTEP=0, tick counter held at 0. iSTOP has no effect. If iSTART=1, go to LOAD.
- LOAD (1 cycle): clear tick counter, step=0, repeat counter=latched iREP, oLED <= table[sel][0], oSTEP <= 0. Go to RUN.
- RUN: tick counter increments every cycle. Tick asserts when tick counter = TICK_DIV-1, and the counter wraps to 0 on that edge. On a tick:
  - If step < PAT_LEN-1: step+1; oLED <= table[sel][step+1].
  - Else if repeat counter != 0: repeat counter-1, step=0, oLED <= table[sel][0].
  - Else: go to DONE.
- DONE (1 cycle): oDONE=1, oLED=0, oSTEP=0. Go to IDLE.

Timing:
- Each step is held exactly TICK_DIV cycles.
- RUN lasts exactly (iREP+1)*PAT_LEN*TICK_DIV cycles.
- Accept-to-first-oLED latency is 2 edges (accept edge, LOAD edge).
- oDONE asserts on the cycle after the final step's last cycle.

Stop and overlapping events:
- iSTOP=1 in LOAD or RUN: next state IDLE, oLED=0, oSTEP=0, no oDONE.
- iSTOP on the same edge as a tick: stop wins.
- iSTOP during DONE: ignored; the pulse still completes.

Widths and wrap:
- Tick counter is clog2(TICK_DIV) bits and is compared with ==, never >=.
- Step counter is 4 bits and wraps to 0 at PAT_LEN-1, never at 15.
- Repeat counter never underflows.

Other rules:
- oBUSY = (state==LOAD || state==RUN); oREADY = (state==IDLE). Both are decoded from the registered state, so they are glitch-free.
- The step tick is generated as an enable, not a derived clock. The block runs single-clock on iCLK.

Decomposition:
Shared package led_pat_pkg:
- State encoding constants: IDLE=0, LOAD=1, RUN=2, DONE=3.
- PAT_LEN default.
- Pattern table constants, bit i = step i:
  - PAT0 = 0,0,0,1,0,1,1,1,0,0,1,1
  - PAT1 = 0,1,0,1,0,1,0,1,0,1,0,1
  - PAT2 = 1,0,0,0,0,0,1,0,0,0,0,0
  - PAT3 = 1,1,1,1,1,1,0,0,0,0,0,0

Sub-module led_step_tick:
- Parameter TICK_DIV; inputs iCLK, iRST, iCLR, iEN; output oTICK, a one-cycle enable.
- Clears on iCLR; counts only while iEN.
- Instantiated once. FSM and table lookup stay in the top module.

Test Plan (TICK_DIV=4, PAT_LEN=12 for all):
- Reset then idle: iRST high 2 cycles -> oREADY=1, oBUSY=0, oLED=0, oDONE=0. Holding iSTOP=1 in IDLE changes nothing.
- Single play: iSEL=0, iREP=0, iSTART pulse -> oLED = 0,0,0,1,0,1,1,1,0,0,1,1, each step held 4 cycles. oSTEP runs 0..11. oDONE pulses exactly 48 cycles after RUN entry, then oREADY=1.
- Repeat wrap: iSEL=2, iREP=2 -> PAT2 played 3 times (144 RUN cycles). oSTEP goes 11->0 twice without oDONE; one oDONE at the end.
- Stop mid-run: iSEL=1, iREP=5, iSTOP at step 5 -> next cycle state IDLE, oLED=0, oSTEP=0, no oDONE. A new iSTART is accepted immediately.
- Overlap: iSTOP on the same edge as a tick -> step does not advance, state goes to IDLE. iSTART during RUN -> ignored, and iSEL changes mid-RUN do not alter oLED.
- Reset mid-RUN: iRST at step 7 of PAT3 -> all outputs return to reset values next cycle, no oDONE. Replay after reset starts from step 0.
